mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the 5-stage pipelined core. It consumes the M-stage address and store data and drives a req/gnt/rvalid data-memory bus, with byte/halfword lane steering, load sign/zero extension and misalignment detection. It returns `ReadDataM` to the W-stage pipeline register and raises `StallM` to the hazard unit while a bus access is outstanding.

## Interface
Parameters:
- `XLEN`, 32, data and address width.
- `TIMEOUT_CYCLES`, 255, maximum cycles spent in REQ+WAIT before the access is aborted with a bus error.

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high reset
- `MemReadM`  in  1  load in M stage
- `MemWriteM`  in  1  store in M stage
- `Funct3M`  in  3  access width/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- `ALUResultM`  in  XLEN  byte address
- `WriteDataM`  in  XLEN  store data, unaligned in register
- `ReadDataM`  out  XLEN  extended load result, valid in DONE
- `StallM`  out  1  freeze F/D/E/M and bubble W
- `MisalignM`  out  1  one-cycle flag: misaligned access suppressed
- `BusErrM`  out  1  one-cycle flag: bus error or timeout
- `dmem_req`  out  1  request valid
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  XLEN  word-aligned address, `{ALUResultM[XLEN-1:2],2'b00}`
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  XLEN  lane-steered store data
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  response valid (loads and store acks)
- `dmem_rdata`  in  XLEN  response word
- `dmem_err`  in  1  error qualifier, sampled with `dmem_rvalid`

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, with no access: `StallM`=0.
- IDLE, with an aligned access: `dmem_req`=1 and `StallM`=1 combinationally. If `dmem_gnt` is high, go to WAIT; otherwise go to REQ.
- REQ: hold `dmem_req` and all request fields stable until `dmem_gnt`, then go to WAIT.
- WAIT: `dmem_req`=0. On `dmem_rvalid`, register `dmem_rdata` and `dmem_err`, then go to DONE.
- DONE: lasts exactly one cycle.
  - `StallM`=0, so the pipeline advances.
  - `ReadDataM` = extended registered data.
  - `BusErrM` = registered error.
  - Next state is IDLE. The access is never reissued, because the M register changes on this edge.
- Misalignment: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No bus request is issued; the store is suppressed.
  - `ReadDataM`=0, `MisalignM`=1 for the cycle; `StallM`=0. FSM stays in IDLE.
- Lane steering:
  - SB: `be` = 0001<<`addr[1:0]`; `wdata` = byte replicated ×4.
  - SH: `be` = 0011<<(2·`addr[1]`); `wdata` = half replicated ×2.
  - SW: `be`=1111.
  - Loads: `be`=1111 for all widths.
- Load extension: select the byte or half at `addr[1:0]`. LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
- `MemReadM` and `MemWriteM` both high: treated as a store.
- Timeout counter:
  - Cleared on leaving IDLE and incremented each cycle in REQ/WAIT.
  - At `TIMEOUT_CYCLES`, force DONE with `BusErrM`=1 and `ReadDataM`=0. `dmem_req` drops.
- `dmem_rvalid` or `dmem_gnt` arriving in IDLE or DONE is ignored (stale response).

## Timing
- Reset values: state IDLE, counter 0, data register 0.
  - Outputs: `dmem_req`=0, `StallM`=0, `ReadDataM`=0, `MisalignM`=0, `BusErrM`=0, `dmem_be`=0, `dmem_we`=0.
- Reset mid-access: the FSM returns to IDLE on the next edge and `dmem_req` drops. The pending `rvalid` is discarded.
- Minimum latency (gnt in cycle 0, rvalid in cycle 1): the instruction occupies M for 3 cycles (IDLE-issue, WAIT, DONE). `StallM` is high for cycles 0–1.
- Each gnt wait cycle adds one cycle; each rvalid wait cycle adds one cycle.
- `ReadDataM`, `BusErrM` and `MisalignM` are meaningful only in a cycle where `StallM`=0. The W register captures them on that edge.
- Outputs are glitch-tolerant; the bus may sample `dmem_req` only at `clk` edges.

## Structure
- Add to `types_pkg`:
  - `lsu_state_e` (IDLE, REQ, WAIT, DONE)
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
- Sub-module `lsu_align`, purely combinational:
  - Store side: `be` and `wdata` generation.
  - Load side: byte/half select and extension.
  - Misalign flag.
- The FSM and timeout counter stay in `mem_stage_lsu`.
- The hazard unit ORs `StallM` into `StallF`/`StallD` and the E/M enables, and flushes W.

## Test plan
- LW at 0x100, gnt in cycle 0, rvalid in cycle 1, rdata 0xDEADBEEF → `StallM` high 2 cycles; DONE `ReadDataM`=0xDEADBEEF; `dmem_addr`=0x100, `be`=1111.
- LB at 0x103 with rdata 0x80xxxxxx → `ReadDataM`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 with rdata 0xBEEF0000 → 0x0000BEEF.
- SB 0xAB at 0x201, gnt delayed 3 cycles → `dmem_req` held 4 cycles; `be`=0010, `wdata`=0xABABABAB, `we`=1; ack rvalid → DONE.
- LW at 0x102 → no `dmem_req`, `MisalignM`=1, `StallM`=0, `ReadDataM`=0. SH at 0x001 → no write.
- `TIMEOUT_CYCLES`=4, gnt never asserted → DONE after 4 cycles with `BusErrM`=1. Separately, rvalid with `dmem_err`=1 → `BusErrM`=1 in DONE.
- `reset` asserted in WAIT, then rvalid arrives next cycle → state IDLE, no DONE, `StallM`=0, `ReadDataM`=0.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, funct3 encodings,
// and the alignment rule used by both the steering logic and the FSM.
package types_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] addrLo);
      case (f3)
         F3_H, F3_HU: return addrLo[0];
         F3_W:        return addrLo != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store enables/data replication, load
// byte/half selection with sign or zero extension, and the misalign flag.
module lsu_align import types_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addrLo,
   input  logic [XLEN-1:0] storeData,
   input  logic [XLEN-1:0] loadWord,
   output logic [3:0]      storeBe,
   output logic [XLEN-1:0] storeWdata,
   output logic [XLEN-1:0] loadData,
   output logic            misalign
);

   logic [7:0]  loadByte;
   logic [15:0] loadHalf;

   assign misalign = isMisaligned(funct3, addrLo);
   assign loadByte = loadWord[{addrLo, 3'b000} +: 8];
   assign loadHalf = loadWord[{addrLo[1], 4'b0000} +: 16];

   always_comb begin
      storeBe    = 4'b1111;
      storeWdata = storeData;
      loadData   = loadWord;
      case (funct3)
         F3_B, F3_BU: begin
            storeBe    = 4'b0001 << addrLo;
            storeWdata = {(XLEN/8){storeData[7:0]}};
            loadData   = funct3[2] ? {{(XLEN-8){1'b0}}, loadByte}
                                   : {{(XLEN-8){loadByte[7]}}, loadByte};
         end
         F3_H, F3_HU: begin
            storeBe    = addrLo[1] ? 4'b1100 : 4'b0011;
            storeWdata = {(XLEN/16){storeData[15:0]}};
            loadData   = funct3[2] ? {{(XLEN-16){1'b0}}, loadHalf}
                                   : {{(XLEN-16){loadHalf[15]}}, loadHalf};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid bus FSM with timeout, stalling
// the pipeline while an access is outstanding.
module mem_stage_lsu import types_pkg::*; #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemReadM,
   input  logic            MemWriteM,
   input  logic [2:0]      Funct3M,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] ReadDataM,
   output logic            StallM,
   output logic            MisalignM,
   output logic            BusErrM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e      state, stateN;
   logic [CW-1:0]   toCnt;
   logic [XLEN-1:0] rdataQ, loadData, storeWdata;
   logic [3:0]      storeBe;
   logic            errQ, access, misalign, timeoutHit, capture, abort;

   lsu_align #(.XLEN(XLEN)) uAlign (
      .funct3     (Funct3M),
      .addrLo     (ALUResultM[1:0]),
      .storeData  (WriteDataM),
      .loadWord   (rdataQ),
      .storeBe    (storeBe),
      .storeWdata (storeWdata),
      .loadData   (loadData),
      .misalign   (misalign)
   );

   assign access     = MemReadM | MemWriteM;
   // >= rather than == so a grant on the last REQ cycle still aborts in WAIT.
   assign timeoutHit = toCnt >= CW'(TIMEOUT_CYCLES - 1);

   assign dmem_addr  = {ALUResultM[XLEN-1:2], 2'b00};
   assign dmem_wdata = storeWdata;
   assign dmem_we    = dmem_req & MemWriteM;
   assign dmem_be    = dmem_req ? (MemWriteM ? storeBe : 4'b1111) : 4'b0000;
   assign ReadDataM  = (state == DONE) ? loadData : '0;
   assign BusErrM    = (state == DONE) & errQ;

   always_comb begin
      stateN    = state;
      dmem_req  = 1'b0;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (misalign) begin
                  MisalignM = 1'b1;
               end else begin
                  dmem_req = 1'b1;
                  StallM   = 1'b1;
                  stateN   = dmem_gnt ? WAIT : REQ;
               end
            end
         end
         REQ: begin
            dmem_req = 1'b1;
            StallM   = 1'b1;
            if (dmem_gnt) begin
               stateN = WAIT;
            end else if (timeoutHit) begin
               abort  = 1'b1;
               stateN = DONE;
            end
         end
         WAIT: begin
            StallM = 1'b1;
            if (dmem_rvalid) begin
               capture = 1'b1;
               stateN  = DONE;
            end else if (timeoutHit) begin
               abort  = 1'b1;
               stateN = DONE;
            end
         end
         DONE:    stateN = IDLE;
         default: stateN = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         toCnt  <= '0;
         rdataQ <= '0;
         errQ   <= 1'b0;
      end else begin
         state <= stateN;
         if (state == IDLE)
            toCnt <= '0;
         else if (state == REQ || state == WAIT)
            toCnt <= toCnt + CW'(1);
         if (capture) begin
            rdataQ <= dmem_rdata;
            errQ   <= dmem_err;
         end else if (abort) begin
            rdataQ <= '0;
            errQ   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, misalignment, bus error,
// reset mid-access, and timeout on a second instance with a short limit.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM, dmem_gnt, dmem_rvalid, dmem_err;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM, dmem_rdata;
   logic [31:0] ReadDataM, dmem_addr, dmem_wdata;
   logic        StallM, MisalignM, BusErrM, dmem_req, dmem_we;
   logic [3:0]  dmem_be;

   logic        tMemReadM, tZero;
   logic [31:0] tReadDataM, tAddr, tWdata;
   logic        tStallM, tMisalignM, tBusErrM, tReq, tWe;
   logic [3:0]  tBe;

   int nChecks = 0;
   int nPass   = 0;
   int reqCycles, stallCycles;

   always #5 clk = ~clk;

   mem_stage_lsu dut (
      .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
   );

   mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dutTo (
      .clk(clk), .reset(reset), .MemReadM(tMemReadM), .MemWriteM(tZero),
      .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(tReadDataM), .StallM(tStallM), .MisalignM(tMisalignM), .BusErrM(tBusErrM),
      .dmem_req(tReq), .dmem_we(tWe), .dmem_addr(tAddr), .dmem_be(tBe),
      .dmem_wdata(tWdata), .dmem_gnt(tZero), .dmem_rvalid(tZero),
      .dmem_rdata(32'h0), .dmem_err(tZero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Minimum-latency load: gnt in cycle 0, rvalid in cycle 1, DONE in cycle 2.
   task automatic loadOp(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic err, input logic [31:0] exp);
      MemReadM = 1'b1; Funct3M = f3; ALUResultM = addr; dmem_gnt = 1'b1;
      #1;
      chk({tag, "_req"}, dmem_req, 1);
      chk({tag, "_stall0"}, StallM, 1);
      chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({tag, "_be"}, dmem_be, 4'b1111);
      chk({tag, "_we"}, dmem_we, 0);
      tick();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_err = err;
      #1;
      chk({tag, "_waitReq"}, dmem_req, 0);
      chk({tag, "_stall1"}, StallM, 1);
      tick();
      dmem_rvalid = 1'b0; dmem_err = 1'b0;
      #1;
      chk({tag, "_doneStall"}, StallM, 0);
      chk({tag, "_data"}, ReadDataM, exp);
      chk({tag, "_err"}, BusErrM, {31'b0, err});
      MemReadM = 1'b0;
      tick();
   endtask

   task automatic storeOp(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] expBe, input logic [31:0] expWd);
      MemWriteM = 1'b1; Funct3M = f3; ALUResultM = addr; WriteDataM = wd; dmem_gnt = 1'b1;
      #1;
      chk({tag, "_req"}, dmem_req, 1);
      chk({tag, "_we"}, dmem_we, 1);
      chk({tag, "_be"}, dmem_be, expBe);
      chk({tag, "_wdata"}, dmem_wdata, expWd);
      tick();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
      tick();
      dmem_rvalid = 1'b0;
      #1;
      chk({tag, "_doneStall"}, StallM, 0);
      MemWriteM = 1'b0; MemReadM = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
      ALUResultM = '0; WriteDataM = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      dmem_rdata = '0; dmem_err = 1'b0; tMemReadM = 1'b0; tZero = 1'b0;
      repeat (2) tick();
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", StallM, 0);
      chk("rst_data", ReadDataM, 0);
      chk("rst_mis", MisalignM, 0);
      chk("rst_err", BusErrM, 0);
      chk("rst_be", dmem_be, 0);
      chk("rst_we", dmem_we, 0);
      reset = 1'b0;
      tick();

      loadOp("lw",  3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
      loadOp("lb",  3'b000, 32'h103, 32'h80123456, 1'b0, 32'hFFFFFF80);
      loadOp("lbu", 3'b100, 32'h103, 32'h80123456, 1'b0, 32'h00000080);
      loadOp("lhu", 3'b101, 32'h102, 32'hBEEF0000, 1'b0, 32'h0000BEEF);
      loadOp("lh",  3'b001, 32'h100, 32'h12348765, 1'b0, 32'hFFFF8765);
      loadOp("lb1", 3'b000, 32'h101, 32'h00007F00, 1'b0, 32'h0000007F);

      // SB with gnt held off for 3 cycles: request stays up 4 cycles
      MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h201; WriteDataM = 32'h123456AB;
      dmem_gnt = 1'b0;
      #1;
      chk("sb_be", dmem_be, 4'b0010);
      chk("sb_wdata", dmem_wdata, 32'hABABABAB);
      chk("sb_we", dmem_we, 1);
      chk("sb_addr", dmem_addr, 32'h200);
      reqCycles = 0;
      for (int i = 0; i < 3; i++) begin
         if (dmem_req) reqCycles++;
         tick();
      end
      dmem_gnt = 1'b1;
      #1;
      if (dmem_req) reqCycles++;
      chk("sb_beHeld", dmem_be, 4'b0010);
      chk("sb_reqCycles", reqCycles, 4);
      tick();
      dmem_gnt = 1'b0;
      #1;
      chk("sb_waitReq", dmem_req, 0);
      chk("sb_waitStall", StallM, 1);
      dmem_rvalid = 1'b1;
      tick();
      dmem_rvalid = 1'b0;
      #1;
      chk("sb_doneStall", StallM, 0);
      chk("sb_doneErr", BusErrM, 0);
      MemWriteM = 1'b0;
      tick();

      storeOp("sh", 3'b001, 32'h202, 32'hFFFF1234, 4'b1100, 32'h12341234);
      storeOp("sw", 3'b010, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
      MemReadM = 1'b1;
      storeOp("rdwr", 3'b010, 32'h400, 32'h11223344, 4'b1111, 32'h11223344);

      // Misaligned word load: suppressed, one-cycle flag, stale gnt ignored
      MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h102; dmem_gnt = 1'b1;
      #1;
      chk("mis_req", dmem_req, 0);
      chk("mis_flag", MisalignM, 1);
      chk("mis_stall", StallM, 0);
      chk("mis_data", ReadDataM, 0);
      MemReadM = 1'b0; dmem_gnt = 1'b0;
      tick();
      chk("mis_clear", MisalignM, 0);
      MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h001;
      #1;
      chk("mis_shReq", dmem_req, 0);
      chk("mis_shWe", dmem_we, 0);
      chk("mis_shFlag", MisalignM, 1);
      MemWriteM = 1'b0;
      tick();

      loadOp("berr", 3'b010, 32'h300, 32'h55AA55AA, 1'b1, 32'h55AA55AA);
      chk("berr_clear", BusErrM, 0);

      // Reset while in WAIT; the late rvalid must not produce a DONE
      MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h500; dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      #1;
      chk("rstw_stall", StallM, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0; MemReadM = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      #1;
      chk("rstw_req", dmem_req, 0);
      chk("rstw_stall0", StallM, 0);
      chk("rstw_data0", ReadDataM, 0);
      tick();
      dmem_rvalid = 1'b0;
      #1;
      chk("rstw_stall1", StallM, 0);
      chk("rstw_data1", ReadDataM, 0);
      chk("rstw_err", BusErrM, 0);

      // Timeout with limit 4 and no grant: 1 issue cycle + 4 REQ cycles
      tMemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h600;
      #1;
      chk("to_stall0", tStallM, 1);
      stallCycles = 0;
      for (int i = 0; i < 20 && tStallM; i++) begin
         stallCycles++;
         tick();
      end
      chk("to_cycles", stallCycles, 5);
      chk("to_err", tBusErrM, 1);
      chk("to_data", tReadDataM, 0);
      chk("to_req", tReq, 0);
      tMemReadM = 1'b0;
      tick();
      chk("to_errClear", tBusErrM, 0);
      chk("to_idle", tStallM, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
